// File: rtl/fft_pkg.sv
// Shared FFT sequencer types: state encoding and bit-reverse helper.
package fft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_UNLOAD,
        S_DONE
    } state_t;

    localparam int MAX_BITS = 8;

    // Reverses the low n bits of v; bits above n come back as zero.
    function automatic logic [MAX_BITS-1:0] bitrev(
        input logic [MAX_BITS-1:0] v,
        input int                  n
    );
        logic [MAX_BITS-1:0] r;
        logic [MAX_BITS-1:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < n) begin
                r = {r[MAX_BITS-2:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Load address generator: sample count to bit-reversed bank/word address.
module fft_bitrev_addr
    import fft_pkg::*;
#(
    parameter int NUMSTAGES = 5
) (
    input  logic [NUMSTAGES-1:0] count,
    output logic [1:0]           bank,
    output logic [NUMSTAGES-3:0] addr
);

    logic [NUMSTAGES-1:0] rev;

    assign rev  = NUMSTAGES'(bitrev(MAX_BITS'(count), NUMSTAGES));
    assign bank = rev[1:0];
    assign addr = rev[NUMSTAGES-1:2];

endmodule

// File: rtl/fft_sequencer.sv
// Frame sequencer for a radix-2 FFT: load, per-stage run, natural-order unload.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int NUMSTAGES  = 5,
    parameter int NUMSAMPLES = 32,
    parameter int WORDSIZE   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORDSIZE-1:0]  in_data,
    output logic [3:0]           wr_we,
    output logic [NUMSTAGES-3:0] wr_addr,
    output logic [WORDSIZE-1:0]  wr_data,
    output logic                 ld_data_r,
    output logic                 en_r,
    output logic [2:0]           stage_num_r,
    input  logic                 stage_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           rd_bank,
    output logic [NUMSTAGES-3:0] rd_addr,
    output logic                 frame_done
);

    localparam logic [NUMSTAGES-1:0] LAST_K = NUMSTAGES'(NUMSAMPLES - 1);
    localparam logic [2:0]           LAST_S = 3'(NUMSTAGES - 1);

    state_t               state;
    state_t               state_n;
    logic [NUMSTAGES-1:0] cnt;
    logic [NUMSTAGES-1:0] j;
    logic [1:0]           ld_bank;
    logic [NUMSTAGES-3:0] ld_addr;
    logic                 accept;

    fft_bitrev_addr #(
        .NUMSTAGES(NUMSTAGES)
    ) u_addr (
        .count(cnt),
        .bank (ld_bank),
        .addr (ld_addr)
    );

    assign accept  = in_valid & in_ready;
    assign rd_bank = j[1:0];
    assign rd_addr = j[NUMSTAGES-1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_n = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_K) state_n = S_ARM;
            end
            S_ARM:  state_n = S_RUN;
            S_RUN: begin
                if (stage_done)
                    state_n = (stage_num_r == LAST_S) ? S_UNLOAD : S_ARM;
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && j == LAST_K) state_n = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            j           <= '0;
            wr_we       <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            ld_data_r   <= 1'b0;
            en_r        <= 1'b0;
            stage_num_r <= '0;
        end else begin
            wr_we <= '0;
            en_r  <= (state_n == S_RUN);
            if (state == S_IDLE && start) cnt <= '0;
            // Write strobe lags acceptance by one cycle.
            if (accept) begin
                cnt     <= cnt + 1'b1;
                wr_we   <= 4'b0001 << ld_bank;
                wr_addr <= ld_addr;
                wr_data <= in_data;
            end
            if (accept && cnt == LAST_K) begin
                ld_data_r   <= 1'b1;
                stage_num_r <= '0;
            end
            if (state == S_RUN && stage_done && stage_num_r != LAST_S)
                stage_num_r <= stage_num_r + 3'd1;
            if (out_valid && out_ready)
                j <= (j == LAST_K) ? '0 : j + 1'b1;
            if (state == S_DONE) begin
                ld_data_r   <= 1'b0;
                stage_num_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: directed frames, gaps and resets.
module tb_fft_sequencer;

    localparam int NS = 5;
    localparam int N  = 32;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    wr_we;
    logic [NS-3:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          ld_data_r;
    logic          en_r;
    logic [2:0]    stage_num_r;
    logic          stage_done;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    rd_bank;
    logic [NS-3:0] rd_addr;
    logic          frame_done;

    fft_sequencer #(
        .NUMSTAGES (NS),
        .NUMSAMPLES(N),
        .WORDSIZE  (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr_we      (wr_we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ld_data_r  (ld_data_r),
        .en_r       (en_r),
        .stage_num_r(stage_num_r),
        .stage_done (stage_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fd_count = 0;
    int frame_id = 0;

    // Hand-computed 5-bit bit reversal of 0..31.
    int br[32] = '{0, 16, 8, 24, 4, 20, 12, 28,
                   2, 18, 10, 26, 6, 22, 14, 30,
                   1, 17, 9, 25, 5, 21, 13, 29,
                   3, 19, 11, 27, 7, 23, 15, 31};

    logic [22:0] exp_wr[$];
    logic [4:0]  exp_rd[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {in_ready, wr_we, wr_addr, wr_data, ld_data_r, en_r,
                   stage_num_r, out_valid, rd_bank, rd_addr, frame_done}, 0);
    endtask

    // Write monitor
    always @(negedge clk) begin
        if (wr_we !== 4'b0000) begin
            if (exp_wr.size() == 0) chk("wr_extra", wr_we, 0);
            else chk("wr", {wr_we, wr_addr, wr_data}, exp_wr.pop_front());
        end
    end

    // Unload monitor: head must be presented until accepted
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_rd.size() == 0) chk("rd_extra", out_valid, 0);
            else begin
                chk("rd", {rd_addr, rd_bank}, exp_rd[0]);
                if (out_ready) void'(exp_rd.pop_front());
            end
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic do_reset(input string name);
        start      = 1'b0;
        stage_done = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        rst        = 1'b1;
        #1;
        chk_zero(name);
        chk({name, "_wrq"}, exp_wr.size(), 0);
        exp_wr.delete();
        exp_rd.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero({name, "_post"});
        @(posedge clk); #1;
    endtask

    task automatic load_frame(input int abort_at, input bit gaps,
                              output bit aborted);
        logic [4:0] r;
        aborted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == abort_at) begin
                @(negedge clk); #1;
                do_reset("rst_load");
                aborted = 1'b1;
                return;
            end
            if (gaps && (k % 3 == 1)) begin
                in_valid = 1'b0;
                in_data  = 16'hDEAD;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = W'(16'h1000 + frame_id * 256 + k);
            r = 5'(br[k]);
            exp_wr.push_back({4'b0001 << r[1:0], r[4:2], in_data});
            @(negedge clk);
            chk("in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        chk("ld_data_r", ld_data_r, 1);
        chk("in_ready_off", in_ready, 0);
        chk("arm_stage0", stage_num_r, 0);
    endtask

    task automatic run_stages(input int abort_at, output bit aborted);
        aborted = 1'b0;
        for (int s = 0; s < NS; s++) begin
            chk("arm_en", en_r, 0);
            chk("arm_stage", stage_num_r, s);
            if (s == 1) stage_done = 1'b1;
            @(posedge clk); #1;
            stage_done = 1'b0;
            if (s == 2) start = 1'b1;
            @(negedge clk);
            chk("run_en", en_r, 1);
            chk("run_stage", stage_num_r, s);
            if (s == abort_at) begin
                #1;
                do_reset("rst_run");
                aborted = 1'b1;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("run_hold", {en_r, in_ready, stage_num_r}, {1'b1, 1'b0, 3'(s)});
            if (s == NS - 1) begin
                for (int j = 0; j < N; j++) exp_rd.push_back(5'(j));
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            stage_done = 1'b1;
            @(posedge clk); #1;
            stage_done = 1'b0;
            @(negedge clk);
        end
        chk("unload_entry", out_valid, 1);
        chk("stage_hold", stage_num_r, NS - 1);
    endtask

    task automatic unload_frame();
        int i;
        int fd_before;
        i = 0;
        fd_before = fd_count;
        while (frame_done !== 1'b1 && i < 200) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            i++;
            @(negedge clk);
        end
        if (i >= 200) chk("unload_timeout", frame_done, 1);
        chk("unload_cycles", i, 63);
        chk("rd_all", exp_rd.size(), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("frame_done_once", fd_count - fd_before, 1);
        chk("idle_after", {frame_done, out_valid, ld_data_r, stage_num_r, en_r}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit ab;
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        stage_done = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk); #1;
        chk_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_release");
        @(posedge clk); #1;

        frame_id = 0;
        load_frame(-1, 1'b0, ab);
        run_stages(-1, ab);
        unload_frame();

        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        frame_id = 1;
        load_frame(-1, 1'b1, ab);
        run_stages(-1, ab);
        unload_frame();

        frame_id = 2;
        load_frame(17, 1'b0, ab);
        chk("abort_load", ab, 1);

        frame_id = 3;
        load_frame(-1, 1'b0, ab);
        run_stages(3, ab);
        chk("abort_run", ab, 1);

        frame_id = 4;
        load_frame(-1, 1'b0, ab);
        run_stages(-1, ab);
        unload_frame();

        repeat (3) @(posedge clk);
        #1;
        chk("frames_done", fd_count, 3);
        chk("wr_q_empty", exp_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter NUMSTAGES, default 5: number of radix-2 stages.
REQ-002 SHALL have parameter NUMSAMPLES, default 32: points per frame, equal to 2**NUMSTAGES.
REQ-003 SHALL have parameter WORDSIZE, default 16: sample word width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: begin a frame; sampled only in IDLE.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream sample present.
REQ-008 SHALL have port in_ready, output, 1 bit: sample accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_data, input, WORDSIZE bits: incoming time-domain sample.
REQ-010 SHALL have port wr_we, output, 4 bits: one-hot bank write enable during LOAD.
REQ-011 SHALL have port wr_addr, output, NUMSTAGES-2 bits: bank word address during LOAD.
REQ-012 SHALL have port wr_data, output, WORDSIZE bits: registered copy of in_data.
REQ-013 SHALL have port ld_data_r, output, 1 bit: frame loaded; to stage control.
REQ-014 SHALL have port en_r, output, 1 bit: stage enable; to stage control.
REQ-015 SHALL have port stage_num_r, output, 3 bits: current stage index; to stage control.
REQ-016 SHALL have port stage_done, input, 1 bit: stage-complete pulse from stage control.
REQ-017 SHALL have port out_valid, output, 1 bit: unload read request valid.
REQ-018 SHALL have port out_ready, input, 1 bit: downstream accepts a request.
REQ-019 SHALL have ports rd_bank (2 bits) and rd_addr (NUMSTAGES-2 bits), output: unload location.
REQ-020 SHALL have port frame_done, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-021 SHALL implement the states IDLE, LOAD, ARM, RUN, UNLOAD and DONE.
REQ-022 IDLE: in_ready=0, en_r=0, ld_data_r=0; start=1 moves to LOAD with the sample counter at 0.
REQ-023 LOAD: in_ready=1; each accepted sample with count k (0..NUMSAMPLES-1) is written to bit-reverse(k).
REQ-024 LOAD addressing: bank = bitrev(k)[1:0], address = bitrev(k)[NUMSTAGES-1:2], driven on wr_we/wr_addr/wr_data one cycle after acceptance.
REQ-025 After the NUMSAMPLES-th acceptance the block SHALL deassert in_ready the next cycle, set ld_data_r=1 and go to ARM with stage_num_r=0.
REQ-026 ARM: en_r=0 for exactly one cycle, then RUN.
REQ-027 RUN: en_r=1; stage_done=1 with stage_num_r<NUMSTAGES-1 increments stage_num_r and returns to ARM.
REQ-028 RUN: stage_done=1 with stage_num_r=NUMSTAGES-1 goes to UNLOAD; stage_num_r holds its value.
REQ-029 stage_done outside RUN SHALL be ignored.
REQ-030 UNLOAD: out_valid=1 with natural-order index j: rd_bank=j[1:0], rd_addr=j[NUMSTAGES-1:2]; j advances only when out_ready=1.
REQ-031 UNLOAD: out_ready low SHALL hold j, rd_bank and rd_addr stable.
REQ-032 After the last index is accepted the block SHALL go to DONE and assert frame_done for one cycle, then return to IDLE with ld_data_r=0 and stage_num_r=0.
REQ-033 start SHALL be ignored in every state except IDLE.
REQ-034 in_valid without in_ready SHALL cause no write.

Reset
REQ-035 rst SHALL force IDLE immediately, in any state including mid-LOAD, mid-RUN or mid-UNLOAD.
REQ-036 rst SHALL clear all counters and all outputs to 0; a partial frame is discarded.

Structure
REQ-037 State encodings and a shared bit-reverse function SHALL reside in package fft_pkg.
REQ-038 Load address generation SHALL be sub-module fft_bitrev_addr (count in, bank/addr out).

Verification
REQ-039 Bench: 32 samples with continuous in_valid -> wr_we/wr_addr follow bit-reversed order (k=1 -> bank 0, addr 4); ld_data_r=1 after the 32nd sample.
REQ-040 Bench: stage_done pulses in RUN -> stage_num_r steps 0..4, each step preceded by exactly one en_r=0 cycle; after the 5th pulse the block enters UNLOAD.
REQ-041 Bench: out_ready toggled 1010... in UNLOAD -> 32 requests j=0..31 with no skips or repeats; frame_done pulses exactly once.
REQ-042 Bench: in_valid gaps and start pulses during RUN -> no extra writes, no restart.
REQ-043 Bench: rst asserted at sample 17 and at stage 3 -> immediate IDLE with all outputs 0; the next frame completes normally.
